// File: rtl/filter_align_ctrl_5x5_if.sv
// Pixel input stream into the 5x5 aligner controller:
// valid-qualified pixel, start-of-frame marker and frame geometry.
interface filter_align_ctrl_5x5_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic                  i_vld;
  logic                  i_sof;
  logic [DATA_WIDTH-1:0] i_x;
  logic [ADDR_WIDTH-1:0] i_width;
  logic [ADDR_WIDTH-1:0] i_height;

  modport master (
    output i_vld,
    output i_sof,
    output i_x,
    output i_width,
    output i_height
  );

  modport slave (
    input i_vld,
    input i_sof,
    input i_x,
    input i_width,
    input i_height
  );
endinterface

// File: rtl/filter_align_ctrl_5x5.sv
// Raster-scan controller for the 5x5 line/pixel aligner.
// Optional sticky o_err output: define FILTER_ALIGN_CTRL_ERR_EN.
module filter_align_ctrl_5x5 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_WIDTH  = 1920
) (
  input  logic                  clk,
  input  logic                  rst,
  filter_align_ctrl_5x5_if.slave s,
  output logic                  o_en,
  output logic [DATA_WIDTH-1:0] o_x,
  output logic [1:0]            o_sel_ln,
  output logic [2:0]            o_case_sel_ln,
  output logic [1:0]            o_sel_px,
  output logic [2:0]            o_case_sel_px,
  output logic [ADDR_WIDTH-1:0] o_addr_ln,
  output logic [ADDR_WIDTH-1:0] o_addr_px,
  output logic                  o_win_vld,
  output logic [ADDR_WIDTH-1:0] o_win_row,
  output logic [ADDR_WIDTH-1:0] o_win_col,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_busy
`ifdef FILTER_ALIGN_CTRL_ERR_EN
  ,
  output logic                  o_err
`endif
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_MAX = ADDR_WIDTH'(MAX_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LP_MIN = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_TWO = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] LP_FOUR = ADDR_WIDTH'(4);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_row;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0] r_w;
  logic [ADDR_WIDTH-1:0] r_h;

  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_x;
  logic [1:0]            r_sel_ln;
  logic [1:0]            r_sel_px;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_win_vld;
  logic [ADDR_WIDTH-1:0] r_win_row;
  logic [ADDR_WIDTH-1:0] r_win_col;
  logic                  r_sof;
  logic                  r_eof;
  logic                  r_busy;

  logic                  w_start;
  logic                  w_acc;
  logic [ADDR_WIDTH-1:0] w_row;
  logic [ADDR_WIDTH-1:0] w_col;
  logic [ADDR_WIDTH-1:0] w_wcl;
  logic [ADDR_WIDTH-1:0] w_hcl;
  logic [ADDR_WIDTH-1:0] w_w;
  logic [ADDR_WIDTH-1:0] w_h;
  logic                  w_last_col;
  logic                  w_last;
  logic                  w_win;

  // A SOF restarts the frame even mid-frame, so the pixel always lands at (0,0)
  assign w_start = s.i_vld & s.i_sof;
  assign w_acc   = s.i_vld & (s.i_sof | (r_state == ACTIVE));
  assign w_row   = w_start ? '0 : r_row;
  assign w_col   = w_start ? '0 : r_col;

  always_comb begin
    w_wcl = s.i_width;
    if (s.i_width > LP_MAX) begin
      w_wcl = LP_MAX;
    end else if (s.i_width < LP_MIN) begin
      w_wcl = LP_MIN;
    end
    w_hcl = s.i_height;
    if (s.i_height < LP_MIN) begin
      w_hcl = LP_MIN;
    end
  end

  assign w_w        = w_start ? w_wcl : r_w;
  assign w_h        = w_start ? w_hcl : r_h;
  assign w_last_col = (w_col == w_w - LP_ONE);
  assign w_last     = w_last_col & (w_row == w_h - LP_ONE);
  assign w_win      = (w_row >= LP_FOUR) & (w_col >= LP_FOUR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_w       <= LP_MIN;
      r_h       <= LP_MIN;
      r_en      <= 1'b0;
      r_x       <= '0;
      r_sel_ln  <= '0;
      r_sel_px  <= '0;
      r_addr    <= '0;
      r_win_vld <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_en      <= w_acc;
      r_sof     <= w_acc & w_start;
      r_eof     <= w_acc & w_last;
      r_win_vld <= w_acc & w_win;
      r_win_row <= (w_acc & w_win) ? w_row - LP_TWO : '0;
      r_win_col <= (w_acc & w_win) ? w_col - LP_TWO : '0;
      if (w_acc) begin
        r_x      <= s.i_x;
        r_sel_ln <= w_row[1:0];
        r_sel_px <= w_col[1:0];
        r_addr   <= w_col;
        r_w      <= w_w;
        r_h      <= w_h;
        if (w_last) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_row   <= '0;
          r_col   <= '0;
        end else begin
          r_state <= ACTIVE;
          r_busy  <= 1'b1;
          if (w_last_col) begin
            r_col <= '0;
            r_row <= w_row + LP_ONE;
          end else begin
            r_col <= w_col + LP_ONE;
            r_row <= w_row;
          end
        end
      end
    end
  end

`ifdef FILTER_ALIGN_CTRL_ERR_EN
  logic r_err;

  // Stray pixel in IDLE or SOF inside an active frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (s.i_vld & ((r_state == ACTIVE) == s.i_sof)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

  assign o_en          = r_en;
  assign o_x           = r_x;
  assign o_sel_ln      = r_sel_ln;
  assign o_case_sel_ln = {1'b0, r_sel_ln};
  assign o_sel_px      = r_sel_px;
  assign o_case_sel_px = {1'b0, r_sel_px};
  assign o_addr_ln     = r_addr;
  assign o_addr_px     = r_addr;
  assign o_win_vld     = r_win_vld;
  assign o_win_row     = r_win_row;
  assign o_win_col     = r_win_col;
  assign o_sof         = r_sof;
  assign o_eof         = r_eof;
  assign o_busy        = r_busy;

endmodule
